// File: rtl/cnn_pkg.sv
// Shared CNN datapath defaults (also used by the DMA and filter buffer) and the writeback state encoding.
package cnn_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 20;
   localparam int BLOCK_SIZE = 150;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DRAIN,
      DONE
   } wb_state_t;

endpackage

// File: rtl/wb_block_buffer.sv
// Block staging buffer: one synchronous write port, one asynchronous read port, contents never reset.
module wb_block_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 150,
   parameter int IDX_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_WIDTH-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [IDX_WIDTH-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/result_writeback.sv
// Fills a BLOCK_SIZE buffer from the result stream, then writes it to memory at ascending addresses, one word per cycle each way.
// in_ready stays low for the whole drain; writes hold while mem_ready is low. Define WB_RELU_EN to store negative words as zero.
module result_writeback #(
   parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
   parameter int BLOCK_SIZE = cnn_pkg::BLOCK_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] total_words,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   input  logic                  mem_ready,
   output logic                  mem_enable,
   output logic                  mem_rw,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  busy,
   output logic                  done
);

   import cnn_pkg::*;

   localparam int IW = $clog2(BLOCK_SIZE + 1);

   wb_state_t             state, stateNext;
   logic [ADDR_WIDTH-1:0] blkAddr, remaining, remainingNext;
   logic [IW-1:0]         target, wrIdx, rdIdx;
   logic                  fillXfer, fillLast, drainCommit, drainLast;
   logic [DATA_WIDTH-1:0] storeData, bufData;

   function automatic logic [IW-1:0] blockTarget(input logic [ADDR_WIDTH-1:0] words);
      if (words > ADDR_WIDTH'(BLOCK_SIZE)) return IW'(BLOCK_SIZE);
      return IW'(words);
   endfunction

   assign fillXfer      = (state == FILL) && in_valid;
   assign fillLast      = fillXfer && ((wrIdx + IW'(1)) == target);
   assign drainCommit   = (state == DRAIN) && mem_ready;
   assign drainLast     = drainCommit && ((rdIdx + IW'(1)) == target);
   assign remainingNext = remaining - ADDR_WIDTH'(target);

`ifdef WB_RELU_EN
   assign storeData = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
   assign storeData = in_data;
`endif

   wb_block_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (BLOCK_SIZE),
      .IDX_WIDTH (IW)
   ) blockBuf (
      .clk  (clk),
      .we   (fillXfer),
      .waddr(wrIdx),
      .wdata(storeData),
      .raddr(rdIdx),
      .rdata(bufData)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      in_ready    = 1'b0;
      mem_enable  = 1'b0;
      mem_address = '0;
      mem_data    = '0;
      done        = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) stateNext = (total_words == '0) ? DONE : FILL;
         end
         FILL: begin
            in_ready = 1'b1;
            if (fillLast) stateNext = DRAIN;
         end
         DRAIN: begin
            mem_enable  = 1'b1;
            mem_address = blkAddr + ADDR_WIDTH'(rdIdx);
            mem_data    = bufData;
            if (drainLast) stateNext = (remainingNext == '0) ? DONE : FILL;
         end
         DONE: begin
            done      = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign mem_rw = mem_enable;

   // rdIdx returns to 0 on the last commit so the read index never points past the buffer.
   always_ff @(posedge clk) begin
      if (reset) begin
         blkAddr   <= '0;
         remaining <= '0;
         target    <= '0;
         wrIdx     <= '0;
         rdIdx     <= '0;
      end else begin
         if (state == IDLE && start) begin
            blkAddr   <= base_addr;
            remaining <= total_words;
            target    <= blockTarget(total_words);
            wrIdx     <= '0;
         end
         if (fillXfer) wrIdx <= wrIdx + IW'(1);
         if (drainCommit) rdIdx <= drainLast ? '0 : rdIdx + IW'(1);
         if (drainLast) begin
            blkAddr   <= blkAddr + ADDR_WIDTH'(target);
            remaining <= remainingNext;
            target    <= blockTarget(remainingNext);
            wrIdx     <= '0;
         end
      end
   end

endmodule
